// File: rtl/snake_control.sv
// Sequencing FSM for the snake datapath: clear, init, draw, food, wait, move/shift, erase, check, dead.
// Latency: strobes are registered Moore outputs, valid in the same cycle as the state they decode.
// Backpressure: none; the datapath is slaved to the strobes, WAIT paces play on the move tick.
//
// Ports: clk, rst (async, active-low); go starts/restarts; key_up/down/left/right set the
// pending heading; isDead/inc_length come back from the datapath. Outputs are the datapath
// load/draw/address strobes, cnt_status (pixel 0..15 of a 4x4 cell), dir (heading) and length.
// Optional feature macro: SNAKE_ANTI_REVERSE_EN drops key requests that reverse the heading.
module snake_control #(
    parameter int INIT_LEN    = 4,
    parameter int MAX_LEN     = 2047,
    parameter int TICK_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        go,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        isDead,
    input  logic        inc_length,
    output logic        reset_ram,
    output logic        ld_head,
    output logic        ld_q_def,
    output logic        inc_address,
    output logic        rst_address,
    output logic        draw_q,
    output logic        draw_curr,
    output logic        food_en,
    output logic        check_inc,
    output logic        lock,
    output logic        update_head,
    output logic        ld_head_into_prev,
    output logic        ld_q_into_curr,
    output logic        ld_prev_into_q,
    output logic        ld_curr_into_prev,
    output logic [3:0]  cnt_status,
    output logic [2:0]  dir,
    output logic [10:0] length
);

    typedef enum logic [4:0] {
        S_IDLE, S_CLEAR, S_INIT_HEAD, S_INIT_Q,
        S_DRAW_RST, S_FETCH, S_PIX, S_DRAW_INC,
        S_FOOD, S_WAIT, S_MOVE,
        S_SH_READ, S_SH_LATCH, S_SH_WRITE,
        S_ERASE, S_CHECK, S_DEAD
    } state_t;

    localparam logic [2:0]  DIR_UP    = 3'b100;  // -y
    localparam logic [2:0]  DIR_DOWN  = 3'b110;  // +y
    localparam logic [2:0]  DIR_LEFT  = 3'b000;  // -x
    localparam logic [2:0]  DIR_RIGHT = 3'b001;  // +x
    localparam logic [10:0] INIT_LEN_W = 11'(INIT_LEN);
    localparam logic [10:0] MAX_LEN_W  = 11'(MAX_LEN);
    localparam logic [31:0] TICK_LAST  = 32'(TICK_CYCLES - 1);

    state_t      state, state_nxt;
    logic [10:0] cnt, cnt_nxt;     // shared cycle counter: CLEAR, INIT_Q and pixel sweeps
    logic [10:0] seg, seg_nxt;     // mirrors the datapath segment address
    logic [31:0] tick_cnt;
    logic        tick_last;
    logic        dead_pend;        // isDead seen at the end of a PIX sweep
    logic [2:0]  pending;
    logic [2:0]  key_dir;
    logic        key_vld;
    logic        is_reverse;
    logic        key_ok;

    assign tick_last = (tick_cnt == TICK_LAST);

    // Key decode, fixed priority up > down > left > right.
    always_comb begin
        key_dir = pending;
        key_vld = 1'b1;
        if (key_up)         key_dir = DIR_UP;
        else if (key_down)  key_dir = DIR_DOWN;
        else if (key_left)  key_dir = DIR_LEFT;
        else if (key_right) key_dir = DIR_RIGHT;
        else                key_vld = 1'b0;
    end

`ifdef SNAKE_ANTI_REVERSE_EN
    // Same axis (bit 2 equal) with opposite sign: bit 1 for y, bit 0 for x.
    assign is_reverse = (key_dir[2] == dir[2]) &&
                        (key_dir[2] ? (key_dir[1] != dir[1]) : (key_dir[0] != dir[0]));
`else
    assign is_reverse = 1'b0;
`endif

    assign key_ok = key_vld && !is_reverse;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        seg_nxt   = seg;
        case (state)
            S_IDLE: begin
                if (go) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            S_CLEAR: begin
                if (cnt == 11'd2047) begin
                    state_nxt = S_INIT_HEAD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 11'd1;
                end
            end
            S_INIT_HEAD: begin
                state_nxt = S_INIT_Q;
                cnt_nxt   = '0;
            end
            S_INIT_Q: begin
                if (cnt == INIT_LEN_W - 11'd1) state_nxt = S_DRAW_RST;
                else                           cnt_nxt   = cnt + 11'd1;
            end
            S_DRAW_RST: begin
                state_nxt = S_FETCH;
                seg_nxt   = '0;
            end
            S_FETCH: begin
                state_nxt = S_PIX;
                cnt_nxt   = '0;
            end
            S_PIX: begin
                if (cnt[3:0] == 4'd15) state_nxt = S_DRAW_INC;
                else                   cnt_nxt   = cnt + 11'd1;
            end
            S_DRAW_INC: begin
                if (dead_pend) begin
                    state_nxt = S_DEAD;
                end else if (seg == length - 11'd1) begin
                    state_nxt = S_FOOD;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = S_FETCH;
                    seg_nxt   = seg + 11'd1;
                end
            end
            S_FOOD: begin
                if (cnt[3:0] == 4'd15) state_nxt = S_WAIT;
                else                   cnt_nxt   = cnt + 11'd1;
            end
            S_WAIT: begin
                // Only a tick that lands while waiting counts; earlier ticks are lost.
                if (tick_last) state_nxt = S_MOVE;
            end
            S_MOVE: begin
                state_nxt = S_SH_READ;
                seg_nxt   = '0;
            end
            S_SH_READ:  state_nxt = S_SH_LATCH;
            S_SH_LATCH: state_nxt = S_SH_WRITE;
            S_SH_WRITE: begin
                if (seg == length - 11'd1) begin
                    state_nxt = S_ERASE;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = S_SH_READ;
                    seg_nxt   = seg + 11'd1;
                end
            end
            S_ERASE: begin
                if (cnt[3:0] == 4'd15) state_nxt = S_CHECK;
                else                   cnt_nxt   = cnt + 11'd1;
            end
            S_CHECK: state_nxt = isDead ? S_DEAD : S_DRAW_RST;
            S_DEAD: begin
                if (go) begin
                    state_nxt = S_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= S_IDLE;
            cnt               <= '0;
            seg               <= '0;
            tick_cnt          <= '0;
            dead_pend         <= 1'b0;
            pending           <= DIR_UP;
            dir               <= DIR_UP;
            length            <= '0;
            reset_ram         <= 1'b0;
            ld_head           <= 1'b0;
            ld_q_def          <= 1'b0;
            inc_address       <= 1'b0;
            rst_address       <= 1'b0;
            draw_q            <= 1'b0;
            draw_curr         <= 1'b0;
            food_en           <= 1'b0;
            check_inc         <= 1'b0;
            lock              <= 1'b0;
            update_head       <= 1'b0;
            ld_head_into_prev <= 1'b0;
            ld_q_into_curr    <= 1'b0;
            ld_prev_into_q    <= 1'b0;
            ld_curr_into_prev <= 1'b0;
            cnt_status        <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            seg      <= seg_nxt;
            tick_cnt <= tick_last ? '0 : tick_cnt + 32'd1;

            // A fresh game starts heading -y unless a key is down right then.
            if (key_ok)                     pending <= key_dir;
            else if (state == S_INIT_HEAD)  pending <= DIR_UP;

            // dir follows pending only on entry to MOVE: one heading change per move.
            if (state == S_INIT_HEAD)       dir <= DIR_UP;
            else if (state_nxt == S_MOVE)   dir <= pending;

            if (state == S_INIT_HEAD)
                length <= INIT_LEN_W;
            else if (state == S_CHECK && inc_length && length < MAX_LEN_W)
                length <= length + 11'd1;

            if (state == S_DRAW_RST)
                dead_pend <= 1'b0;
            else if (state == S_PIX && cnt[3:0] == 4'd15 && isDead)
                dead_pend <= 1'b1;

            // Decode from the next state so each strobe lines up with its state.
            reset_ram         <= (state_nxt == S_CLEAR);
            ld_head           <= (state_nxt == S_INIT_HEAD);
            ld_q_def          <= (state_nxt == S_INIT_Q);
            inc_address       <= (state_nxt == S_CLEAR)    || (state_nxt == S_INIT_Q) ||
                                 (state_nxt == S_DRAW_INC) || (state_nxt == S_SH_WRITE);
            rst_address       <= (state_nxt == S_INIT_HEAD) || (state_nxt == S_DRAW_RST) ||
                                 (state_nxt == S_MOVE);
            draw_q            <= (state_nxt == S_PIX);
            draw_curr         <= (state_nxt == S_ERASE);
            food_en           <= (state_nxt == S_FOOD);
            check_inc         <= (state_nxt == S_CHECK);
            lock              <= (state_nxt == S_WAIT);
            update_head       <= (state_nxt == S_MOVE);
            ld_head_into_prev <= (state_nxt == S_MOVE);
            ld_q_into_curr    <= (state_nxt == S_SH_LATCH);
            ld_prev_into_q    <= (state_nxt == S_SH_WRITE);
            ld_curr_into_prev <= (state_nxt == S_SH_WRITE);
            cnt_status        <= ((state_nxt == S_PIX) || (state_nxt == S_FOOD) ||
                                  (state_nxt == S_ERASE)) ? cnt_nxt[3:0] : 4'd0;
        end
    end

endmodule
